seq_detector_prog: RTL and testbench

Programmable serial pattern detector. It replaces the hard-coded 10110 FSM detector with a single block configured at runtime for pattern, length (1..MAX_LEN) and overlap mode. It has a valid-qualified input stream, a registered match pulse and a saturating match counter. It sits between a serial bit source and the control/status logic of the design.

---
 rtl/seq_detector_prog.sv | 110 +++++++++++
 tb/tb_seq_detector_prog.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: runtime pattern/length/overlap, valid-qualified
// input stream, registered match pulse and saturating match counter.
module seq_detector_prog #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed,
  output logic               cfg_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             r_state;
  // The oldest history bit is always shifted out before it could be compared,
  // so only MAX_LEN-1 bits need storing.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_dout;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic [MAX_LEN-1:0] w_nh;
  logic [LEN_W-1:0]   w_nf;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_cfg_ok;
  logic               w_match;

  assign w_nh     = {r_hist, din};
  assign w_nf     = (r_fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : r_fill + LEN_W'(1);
  assign w_cfg_ok = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  assign w_match = (r_state == RUN) && din_valid && !cfg_load && (w_nf >= r_len)
                   && (((w_nh ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
      r_dout  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_dout <= w_match;

      if (cnt_clr) begin
        r_cnt <= w_match ? CNT_W'(1) : '0;
      end else if (w_match && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (cfg_load) begin
        if (w_cfg_ok) begin
          r_pat   <= pattern;
          r_len   <= pat_len;
          r_ovl   <= overlap;
          r_hist  <= '0;
          r_fill  <= '0;
          r_err   <= 1'b0;
          r_state <= RUN;
        end else begin
          r_err   <= 1'b1;
          r_state <= IDLE;
        end
      end else if ((r_state == RUN) && din_valid) begin
        if (w_match && !r_ovl) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_nh[MAX_LEN-2:0];
          r_fill <= w_nf;
        end
      end
    end
  end

  assign dout      = r_dout;
  assign match_cnt = r_cnt;
  assign armed     = (r_state == RUN);
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: two instances share stimulus, the second
// with a 2-bit counter to exercise saturation.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               din_valid;
  logic               din;
  logic               cnt_clr;

  logic               dout_a, armed_a, cfg_err_a;
  logic [7:0]         match_cnt_a;
  logic               dout_b, armed_b, cfg_err_b;
  logic [1:0]         match_cnt_b;

  int unsigned vectors;
  int unsigned miscompares;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .din_valid(din_valid), .din(din), .cnt_clr(cnt_clr),
    .dout(dout_a), .match_cnt(match_cnt_a), .armed(armed_a), .cfg_err(cfg_err_a)
  );

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .din_valid(din_valid), .din(din), .cnt_clr(cnt_clr),
    .dout(dout_b), .match_cnt(match_cnt_b), .armed(armed_b), .cfg_err(cfg_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_load = 1'b1;
    pattern  = p;
    pat_len  = l;
    overlap  = o;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic b, input logic exp_dout, input string tag);
    din_valid = 1'b1;
    din       = b;
    tick();
    din_valid = 1'b0;
    chk(tag, {31'd0, dout_a}, {31'd0, exp_dout});
  endtask

  task automatic gap(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      tick();
      chk("gap_dout", {31'd0, dout_a}, 32'd0);
    end
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; cfg_load = 1'b0; pattern = '0; pat_len = '0; overlap = 1'b0;
    din_valid = 1'b0; din = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    chk("rst_dout",  {31'd0, dout_a},    32'd0);
    chk("rst_cnt",   {24'd0, match_cnt_a}, 32'd0);
    chk("rst_armed", {31'd0, armed_a},   32'd0);
    chk("rst_err",   {31'd0, cfg_err_a}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: overlapping 10110; upper pattern bits are garbage and must be ignored
    load(8'b1111_0110, 4'd5, 1'b1);
    chk("s1_armed", {31'd0, armed_a},   32'd1);
    chk("s1_err",   {31'd0, cfg_err_a}, 32'd0);
    send(1, 0, "s1_b1"); send(0, 0, "s1_b2"); send(1, 0, "s1_b3"); send(1, 0, "s1_b4");
    send(0, 1, "s1_b5"); send(1, 0, "s1_b6"); send(1, 0, "s1_b7"); send(0, 1, "s1_b8");
    tick();
    chk("s1_idle_dout", {31'd0, dout_a}, 32'd0);
    chk("s1_cnt", {24'd0, match_cnt_a}, 32'd2);

    // 2: non-overlapping; reload leaves the counter alone
    load(8'b0001_0110, 4'd5, 1'b0);
    chk("s2_cnt_kept", {24'd0, match_cnt_a}, 32'd2);
    send(1, 0, "s2_b1"); send(0, 0, "s2_b2"); send(1, 0, "s2_b3"); send(1, 0, "s2_b4");
    send(0, 1, "s2_b5"); send(1, 0, "s2_b6"); send(1, 0, "s2_b7"); send(0, 0, "s2_b8");
    chk("s2_cnt", {24'd0, match_cnt_a}, 32'd3);
    pulse_clr();
    chk("s2_clr", {24'd0, match_cnt_a}, 32'd0);

    // 3: gaps of three invalid cycles between bits
    load(8'b0001_0110, 4'd5, 1'b1);
    send(1, 0, "s3_b1"); gap(3); send(0, 0, "s3_b2"); gap(3);
    send(1, 0, "s3_b3"); gap(3); send(1, 0, "s3_b4"); gap(3);
    send(0, 1, "s3_b5"); gap(3); send(1, 0, "s3_b6"); gap(3);
    send(1, 0, "s3_b7"); gap(3); send(0, 1, "s3_b8"); gap(3);
    chk("s3_cnt", {24'd0, match_cnt_a}, 32'd2);

    // 4: illegal lengths 0 and MAX_LEN+1
    load(8'b0001_0110, 4'd0, 1'b1);
    chk("s4_err0",   {31'd0, cfg_err_a}, 32'd1);
    chk("s4_armed0", {31'd0, armed_a},   32'd0);
    send(1, 0, "s4_b1"); send(0, 0, "s4_b2"); send(1, 0, "s4_b3"); send(1, 0, "s4_b4");
    send(0, 0, "s4_b5");
    load(8'b0001_0110, 4'd9, 1'b1);
    chk("s4_err9",   {31'd0, cfg_err_a}, 32'd1);
    chk("s4_armed9", {31'd0, armed_a},   32'd0);
    send(1, 0, "s4_c1"); send(0, 0, "s4_c2"); send(1, 0, "s4_c3"); send(1, 0, "s4_c4");
    send(0, 0, "s4_c5");
    chk("s4_cnt", {24'd0, match_cnt_a}, 32'd2);
    load(8'b0001_0110, 4'd5, 1'b1);
    chk("s4_err_ok",   {31'd0, cfg_err_a}, 32'd0);
    chk("s4_armed_ok", {31'd0, armed_a},   32'd1);

    // 5: pat_len=1, all ones; 2-bit counter saturates at 3
    load(8'b0000_0001, 4'd1, 1'b1);
    pulse_clr();
    chk("s5_clr_b", {30'd0, match_cnt_b}, 32'd0);
    send(1, 1, "s5_b1"); chk("s5_cnt_b1", {30'd0, match_cnt_b}, 32'd1);
    send(1, 1, "s5_b2"); chk("s5_cnt_b2", {30'd0, match_cnt_b}, 32'd2);
    send(1, 1, "s5_b3"); chk("s5_cnt_b3", {30'd0, match_cnt_b}, 32'd3);
    send(1, 1, "s5_b4"); chk("s5_cnt_b4", {30'd0, match_cnt_b}, 32'd3);
    send(1, 1, "s5_b5"); send(1, 1, "s5_b6");
    chk("s5_dout_b", {31'd0, dout_b},      32'd1);
    chk("s5_sat_b",  {30'd0, match_cnt_b}, 32'd3);
    chk("s5_cnt_a",  {24'd0, match_cnt_a}, 32'd6);
    cnt_clr = 1'b1;
    send(1, 1, "s5_clrhit");
    cnt_clr = 1'b0;
    chk("s5_clrhit_b", {30'd0, match_cnt_b}, 32'd1);
    chk("s5_clrhit_a", {24'd0, match_cnt_a}, 32'd1);
    send(0, 0, "s5_zero");

    // Full-length pattern, non-overlapping
    load(8'b1001_1010, 4'd8, 1'b0);
    send(1, 0, "fl_b1"); send(0, 0, "fl_b2"); send(0, 0, "fl_b3"); send(1, 0, "fl_b4");
    send(1, 0, "fl_b5"); send(0, 0, "fl_b6"); send(1, 0, "fl_b7"); send(0, 1, "fl_b8");

    // cfg_load with a completing bit in the same cycle: bit discarded, no match
    load(8'b0001_0110, 4'd5, 1'b1);
    send(1, 0, "cv_b1"); send(0, 0, "cv_b2"); send(1, 0, "cv_b3"); send(1, 0, "cv_b4");
    din_valid = 1'b1; din = 1'b0;
    load(8'b0001_0110, 4'd5, 1'b1);
    din_valid = 1'b0;
    chk("cv_dout", {31'd0, dout_a}, 32'd0);

    // 6: reset mid-pattern discards progress
    send(1, 0, "s6_b1"); send(0, 0, "s6_b2"); send(1, 0, "s6_b3"); send(1, 0, "s6_b4");
    rst = 1'b1;
    #1;
    chk("s6_async_armed", {31'd0, armed_a},     32'd0);
    chk("s6_async_cnt",   {24'd0, match_cnt_a}, 32'd0);
    tick();
    rst = 1'b0;
    load(8'b0001_0110, 4'd5, 1'b1);
    send(0, 0, "s6_after");
    send(1, 0, "s6_c1"); send(0, 0, "s6_c2"); send(1, 0, "s6_c3"); send(1, 0, "s6_c4");
    send(0, 1, "s6_c5");
    chk("s6_cnt", {24'd0, match_cnt_a}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
